// File: rtl/led_pkg.sv
// Shared types and defaults for the LED fader and its PWM channels.
package led_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  localparam int N_LEDS_DEF   = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int STEP_DIV_DEF = 65536;

  // Full-scale brightness for a PWM counter of the given width.
  function automatic int max_level(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level, fade target, linear step and the
// registered PWM comparator that drives the pin.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                target_bit,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(max_level(PWM_BITS));

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] target;

  // Latch the new target on accept; otherwise walk the level one unit toward it per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      level  <= '0;
    end else if (load) begin
      target <= target_bit ? MAX_LEVEL : '0;
    end else if (tick) begin
      if (level < target) begin
        level <= level + 1'b1;
      end else if (level > target) begin
        level <= level - 1'b1;
      end
    end
  end

  // Registered PWM compare: level 0 is always off, MAX_LEVEL is off one slot per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= (level > pwm_cnt);
    end
  end

  assign at_target = (level == target);

endmodule

// File: rtl/led_fader.sv
// LED fader top: pattern handshake, fade sequencing FSM, step prescaler and
// the shared PWM counter feeding N_LEDS channels.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a new pattern, levels static
//   FADE  | levels stepping toward targets on each prescaler tick
module led_fader
  import led_pkg::*;
#(
  parameter int N_LEDS   = N_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEDS-1:0] pattern,
  input  logic              pattern_valid,
  output logic              pattern_ready,
  output logic [N_LEDS-1:0] led,
  output logic              busy
);

  localparam int                  PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  state_t              state;
  state_t              state_nxt;
  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                out_of_reset;
  logic                tick;
  logic                step;
  logic                accept;
  logic                all_at_target;
  logic [N_LEDS-1:0]   at_target;

  assign tick          = (presc == PRESC_LAST);
  assign pattern_ready = out_of_reset && (state == IDLE);
  assign busy          = (state == FADE);
  assign accept        = pattern_valid && pattern_ready;
  // The accept cycle is still IDLE, so a tick landing there never steps.
  assign step          = tick && (state == FADE);
  assign all_at_target = &at_target;

  // Free-running prescaler and PWM counter; neither restarts on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Holds ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave FADE once the registered (post-step) levels all match.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = FADE;
      FADE: if (all_at_target) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .target_bit (pattern[i]),
      .tick       (step),
      .pwm_cnt    (pwm_cnt),
      .led        (led[i]),
      .at_target  (at_target[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader with small PWM/prescaler so fades finish quickly.
module tb_led_fader;

  localparam int N   = 8;
  localparam int PB  = 4;
  localparam int SD  = 4;
  localparam int MAXL = 15;
  localparam int PER = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pattern;
  logic         pattern_valid;
  logic         pattern_ready;
  logic [N-1:0] led;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  led_fader #(
    .N_LEDS   (N),
    .PWM_BITS (PB),
    .STEP_DIV (SD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .pattern_ready (pattern_ready),
    .led           (led),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: edge count since reset gives prescaler and PWM phase directly.
  int           m_n;
  bit           m_rdy;
  bit           m_busy;
  int           m_lvl [N];
  int           m_tgt [N];
  logic [N-1:0] m_led;
  bit           m_tick;
  bit           m_eq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_rdy = 0; m_busy = 0; m_led = '0;
      for (int i = 0; i < N; i++) begin m_lvl[i] = 0; m_tgt[i] = 0; end
    end else begin
      m_tick = ((m_n % SD) == SD - 1);
      for (int i = 0; i < N; i++) m_led[i] = (m_lvl[i] > (m_n % PER));
      if (!m_busy) begin
        if (m_rdy && pattern_valid) begin
          for (int i = 0; i < N; i++) m_tgt[i] = pattern[i] ? MAXL : 0;
          m_busy = 1;
        end
      end else begin
        m_eq = 1;
        for (int i = 0; i < N; i++) if (m_lvl[i] != m_tgt[i]) m_eq = 0;
        if (m_eq) m_busy = 0;
        else if (m_tick)
          for (int i = 0; i < N; i++)
            if (m_lvl[i] < m_tgt[i]) m_lvl[i]++;
            else if (m_lvl[i] > m_tgt[i]) m_lvl[i]--;
      end
      m_rdy = 1;
      m_n++;
    end
  end

  // Every-cycle compare of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    vectors++;
    if (led !== m_led || pattern_ready !== (m_rdy && !m_busy) || busy !== m_busy) begin
      miscompares++;
      $display("FAIL model_cycle t=%0t led=%h exp=%h ready=%b exp=%b busy=%b exp=%b",
               $time, led, m_led, pattern_ready, (m_rdy && !m_busy), busy, m_busy);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Offer p until accepted; called and returns at a negedge.
  task automatic send(input logic [N-1:0] p);
    int k = 0;
    pattern = p;
    pattern_valid = 1'b1;
    while (!pattern_ready && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) chk("send_timeout", k, 0);
    @(negedge clk);
    pattern_valid = 1'b0;
  endtask

  // Count cycles with busy high, starting at the current negedge.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 400) begin n++; @(negedge clk); end
    if (n >= 400) chk("busy_timeout", n, 0);
  endtask

  // Per-bit on-count over one PWM period must match a steady 0 or MAX_LEVEL.
  task automatic duty(input string name, input logic [N-1:0] mask);
    int cnt [N];
    logic [N-1:0] m;
    m = mask;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < PER; c++) begin
      for (int i = 0; i < N; i++) cnt[i] += int'(led[i]);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) chk($sformatf("%s_bit%0d", name, i), cnt[i], m[i] ? MAXL : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, ones;
    rst_n = 1'b0; pattern = '0; pattern_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(pattern_ready), 0);
    chk("reset_led", int'(led), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Idle for 100 cycles with nothing offered.
    ones = 0;
    for (int c = 0; c < 100; c++) begin
      ones += $countones(led);
      @(negedge clk);
    end
    chk("idle_led_ones", ones, 0);
    chk("idle_ready", int'(pattern_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Full-scale fade up: 15 ticks, first within 4 cycles of accept, plus one exit cycle.
    send(8'hFF);
    busy_len(n);
    chk_range("ff_busy_len", n, 58, 61);
    chk("ff_ready_after", int'(pattern_ready), 1);
    duty("ff_duty", 8'hFF);

    // Mixed pattern from all-on.
    send(8'hA5);
    busy_len(n);
    chk_range("a5_busy_len", n, 58, 61);
    duty("a5_duty", 8'hA5);

    // Hold 0x00 valid during a fade: accepted exactly one cycle after busy falls.
    send(8'hFF);
    pattern = 8'h00;
    pattern_valid = 1'b1;
    busy_len(n);
    chk_range("hold_first_len", n, 58, 61);
    gap = 0;
    while (!busy && gap < 50) begin gap++; @(negedge clk); end
    chk("hold_gap", gap, 1);
    pattern_valid = 1'b0;
    busy_len(n);
    chk_range("hold_second_len", n, 58, 61);
    duty("zero_duty", 8'h00);

    // Reset in the middle of a 0x00 -> 0xFF fade.
    send(8'hFF);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_led", int'(led), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(pattern_ready), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(8'h0F);
    busy_len(n);
    chk_range("0f_busy_len", n, 58, 61);
    duty("0f_duty", 8'h0F);

    // Re-send the current pattern: a single FADE cycle, duty unchanged.
    send(8'h0F);
    busy_len(n);
    chk("same_busy_len", n, 1);
    duty("same_duty", 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
